// File: rtl/nco_phase_det.sv
// Iterative CORDIC (vectoring) phase detector: recovers atan2(fsin, fcos) and the phase step between samples.
// Optional feature macro: NCO_PHASE_DET_INC_EN (previous-phase register and phi_inc_o/inc_valid).
module nco_phase_det #(
  parameter int mpr   = 18,
  parameter int apr   = 32,
  parameter int niter = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           in_valid,
  input  logic [mpr-1:0] fsin_i,
  input  logic [mpr-1:0] fcos_i,
  output logic           in_ready,
  output logic [apr-1:0] phase_o,
  output logic [apr-1:0] phi_inc_o,
  output logic           inc_valid,
  output logic           out_valid
);

  localparam int XW = mpr + 2;
  localparam int IW = $clog2(niter);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // atan(2^-i) in 32-bit turns, rounded
  function automatic logic [31:0] atan_f(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_f = 32'h2000_0000;
      5'd1:  atan_f = 32'h12E4_051E;
      5'd2:  atan_f = 32'h09FB_385B;
      5'd3:  atan_f = 32'h0511_11D4;
      5'd4:  atan_f = 32'h028B_0D43;
      5'd5:  atan_f = 32'h0145_D7E1;
      5'd6:  atan_f = 32'h00A2_F61E;
      5'd7:  atan_f = 32'h0051_7C55;
      5'd8:  atan_f = 32'h0028_BE53;
      5'd9:  atan_f = 32'h0014_5F2F;
      5'd10: atan_f = 32'h000A_2F98;
      5'd11: atan_f = 32'h0005_17CC;
      5'd12: atan_f = 32'h0002_8BE6;
      5'd13: atan_f = 32'h0001_45F3;
      5'd14: atan_f = 32'h0000_A2FA;
      5'd15: atan_f = 32'h0000_517D;
      5'd16: atan_f = 32'h0000_28BE;
      5'd17: atan_f = 32'h0000_145F;
      5'd18: atan_f = 32'h0000_0A30;
      5'd19: atan_f = 32'h0000_0518;
      5'd20: atan_f = 32'h0000_028C;
      5'd21: atan_f = 32'h0000_0146;
      5'd22: atan_f = 32'h0000_00A3;
      5'd23: atan_f = 32'h0000_0051;
      5'd24: atan_f = 32'h0000_0029;
      5'd25: atan_f = 32'h0000_0014;
      5'd26: atan_f = 32'h0000_000A;
      5'd27: atan_f = 32'h0000_0005;
      5'd28: atan_f = 32'h0000_0003;
      5'd29: atan_f = 32'h0000_0001;
      5'd30: atan_f = 32'h0000_0001;
      default: atan_f = 32'h0000_0000;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic [IW-1:0]         iter_r;
  logic signed [XW-1:0]  x_r, y_r;
  logic [apr-1:0]        z_r;
  logic                  zero_r;
  logic                  in_ready_r, out_valid_r;
  logic [apr-1:0]        phase_r;

  logic signed [XW-1:0]  fc_ext_s, fs_ext_s, x_sh_s, y_sh_s;
  logic [31:0]           atan_full_s;
  logic [apr-1:0]        atan_s, phase_s;

  assign fc_ext_s    = $signed({{2{fcos_i[mpr-1]}}, fcos_i});
  assign fs_ext_s    = $signed({{2{fsin_i[mpr-1]}}, fsin_i});
  assign x_sh_s      = x_r >>> iter_r;
  assign y_sh_s      = y_r >>> iter_r;
  assign atan_full_s = atan_f(5'(iter_r)) >> (32 - apr);
  assign atan_s      = atan_full_s[apr-1:0];
  assign phase_s     = zero_r ? {apr{1'b0}} : z_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = S_ITER;
        else          state_s = S_IDLE;
      end
      S_ITER: begin
        if (iter_r == IW'(niter - 1)) state_s = S_OUT;
        else                          state_s = S_ITER;
      end
      S_OUT:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register and handshake flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (clken) begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_r == S_OUT);
    end
  end

  // CORDIC datapath; pre-rotation folds the left half-plane onto the right
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_r  <= {IW{1'b0}};
      x_r     <= {XW{1'b0}};
      y_r     <= {XW{1'b0}};
      z_r     <= {apr{1'b0}};
      zero_r  <= 1'b0;
      phase_r <= {apr{1'b0}};
    end else if (clken) begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            iter_r <= {IW{1'b0}};
            zero_r <= (fsin_i == {mpr{1'b0}}) && (fcos_i == {mpr{1'b0}});
            if (fcos_i[mpr-1]) begin
              x_r <= -fc_ext_s;
              y_r <= -fs_ext_s;
              z_r <= {1'b1, {(apr-1){1'b0}}};
            end else begin
              x_r <= fc_ext_s;
              y_r <= fs_ext_s;
              z_r <= {apr{1'b0}};
            end
          end
        end
        S_ITER: begin
          iter_r <= iter_r + IW'(1);
          if (y_r[XW-1]) begin
            x_r <= x_r - y_sh_s;
            y_r <= y_r + x_sh_s;
            z_r <= z_r - atan_s;
          end else begin
            x_r <= x_r + y_sh_s;
            y_r <= y_r - x_sh_s;
            z_r <= z_r + atan_s;
          end
        end
        S_OUT:   phase_r <= phase_s;
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign phase_o   = phase_r;

`ifdef NCO_PHASE_DET_INC_EN
  logic [apr-1:0] prev_r, phi_inc_r;
  logic           have_prev_r, inc_valid_r;

  // Phase difference against the previous result, mod 2^apr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r      <= {apr{1'b0}};
      phi_inc_r   <= {apr{1'b0}};
      have_prev_r <= 1'b0;
      inc_valid_r <= 1'b0;
    end else if (clken && (state_r == S_OUT)) begin
      phi_inc_r   <= phase_s - prev_r;
      inc_valid_r <= have_prev_r;
      prev_r      <= phase_s;
      have_prev_r <= 1'b1;
    end
  end

  assign phi_inc_o = phi_inc_r;
  assign inc_valid = inc_valid_r;
`else
  assign phi_inc_o = {apr{1'b0}};
  assign inc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nco_phase_det.sv
// Directed bench for nco_phase_det: vector table, busy-input, mid-computation reset and clken-gated loopback.
module tb_nco_phase_det;

`ifdef NCO_PHASE_DET_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif
  localparam int LAT = 17;
  localparam int PTOL = 65536;
  localparam int ITOL = 131072;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] fsin_i = 18'd0;
  logic [17:0] fcos_i = 18'd0;
  logic        in_ready, inc_valid, out_valid;
  logic [31:0] phase_o, phi_inc_o;

  int n_vec = 0;
  int n_miss = 0;
  bit rnd_en = 1'b0;

  nco_phase_det dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .in_ready(in_ready), .phase_o(phase_o),
    .phi_inc_o(phi_inc_o), .inc_valid(inc_valid), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          fc;
    int          fs;
    logic [31:0] ph;
    logic [31:0] inc;
    bit          incv;
  } vec_t;

  vec_t tbl[12];

  task automatic check_exact(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [31:0] got, input logic [31:0] exp, input int tol);
    int d;
    d = $signed(got - exp);
    if (d < 0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h +/-%0d", name, got, exp, tol);
    end
  endtask

  task automatic edge_step(output bit en);
    en = rnd_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    clken = en;
    @(posedge clk);
    #1;
  endtask

  // Apply one sample; lat returns enabled edges from accept to out_valid
  task automatic run_sample(input int fc, input int fs, input bit noise, output int lat);
    bit en, rdy, acc;
    int budget;
    fcos_i = 18'(fc);
    fsin_i = 18'(fs);
    in_valid = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      rdy = in_ready;
      edge_step(en);
      if (en && rdy) acc = 1'b1;
      budget++;
    end
    in_valid = noise;
    if (noise) begin
      fcos_i = 18'd0;
      fsin_i = 18'(-131072);
    end
    lat = 0;
    budget = 0;
    while (acc && !out_valid && budget < 400) begin
      if (noise && lat >= 10) in_valid = 1'b0;
      edge_step(en);
      if (en) lat++;
      budget++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: no out_valid for sample (%0d,%0d), accepted=%0d", fc, fs, acc);
      lat = -1;
    end
  endtask

  initial begin
    int  lat, pulses;
    bit  en;
    real a;

    tbl[0]  = '{131071,       0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[1]  = '{0,       131071, 32'h4000_0000, 32'h4000_0000, 1'b1};
    tbl[2]  = '{-131072,      0, 32'h8000_0000, 32'h4000_0000, 1'b1};
    tbl[3]  = '{0,      -131072, 32'hC000_0000, 32'h4000_0000, 1'b1};
    tbl[4]  = '{0,            0, 32'h0000_0000, 32'h4000_0000, 1'b1};
    tbl[5]  = '{100000,  100000, 32'h2000_0000, 32'h2000_0000, 1'b1};
    tbl[6]  = '{-100000, 100000, 32'h6000_0000, 32'h4000_0000, 1'b1};
    tbl[7]  = '{-100000,-100000, 32'hA000_0000, 32'h4000_0000, 1'b1};
    tbl[8]  = '{100000, -100000, 32'hE000_0000, 32'h4000_0000, 1'b1};
    tbl[9]  = '{-131072,     -1, 32'h8000_0000, 32'hA000_0000, 1'b1};
    tbl[10] = '{131071,      -1, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[11] = '{-131072,-131072, 32'hA000_0000, 32'hA000_0000, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_exact("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_exact("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_exact("rst_phase", phase_o, 32'd0);
    check_exact("rst_phi_inc", phi_inc_o, 32'd0);
    check_exact("rst_inc_valid", {31'd0, inc_valid}, 32'd0);
    repeat (3) edge_step(en);
    check_exact("idle_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_sample(tbl[i].fc, tbl[i].fs, (i == 2), lat);
      check_exact($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      check_near($sformatf("v%0d_phase", i), phase_o, tbl[i].ph, PTOL);
      if (tbl[i].fc == 0 && tbl[i].fs == 0)
        check_exact($sformatf("v%0d_zero_phase", i), phase_o, 32'd0);
      check_exact($sformatf("v%0d_inc_valid", i), {31'd0, inc_valid}, {31'd0, tbl[i].incv & INC_EN});
      if (INC_EN) check_near($sformatf("v%0d_phi_inc", i), phi_inc_o, tbl[i].inc, ITOL);
      else        check_exact($sformatf("v%0d_phi_inc", i), phi_inc_o, 32'd0);
      edge_step(en);
      check_exact($sformatf("v%0d_pulse_clear", i), {31'd0, out_valid}, 32'd0);
      if (i == 2) begin
        repeat (4) edge_step(en);
        check_exact("busy_ignored_no_accept", {31'd0, in_ready}, 32'd1);
        check_exact("busy_ignored_no_pulse", {31'd0, out_valid}, 32'd0);
      end
    end

    // Reset in the middle of the iterations
    fcos_i = 18'd0;
    fsin_i = 18'd131071;
    in_valid = 1'b1;
    edge_step(en);
    in_valid = 1'b0;
    check_exact("busy_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (8) edge_step(en);
    #2 reset_n = 1'b0;
    #1;
    check_exact("midrst_phase", phase_o, 32'd0);
    check_exact("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      edge_step(en);
      if (out_valid) pulses++;
    end
    check_exact("midrst_no_out_valid", 32'(pulses), 32'd0);
    run_sample(131071, 0, 1'b0, lat);
    check_exact("postrst_latency", 32'(lat), 32'(LAT));
    check_near("postrst_phase", phase_o, 32'h0000_0000, PTOL);
    check_exact("postrst_inc_valid", {31'd0, inc_valid}, 32'd0);

    // Loopback of a rotating phasor, step 0x0100_0000, with clken gated 30% of cycles
    rnd_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      a = 6.283185307179586 * real'(k) / 256.0;
      run_sample($rtoi(100000.0 * $cos(a)), $rtoi(100000.0 * $sin(a)), 1'b0, lat);
      check_exact($sformatf("lb%0d_latency", k), 32'(lat), 32'(LAT));
      check_near($sformatf("lb%0d_phase", k), phase_o, 32'(k) << 24, PTOL);
      if (k > 0) begin
        check_exact($sformatf("lb%0d_inc_valid", k), {31'd0, inc_valid}, {31'd0, INC_EN});
        if (INC_EN) check_near($sformatf("lb%0d_phi_inc", k), phi_inc_o, 32'h0100_0000, ITOL);
        else        check_exact($sformatf("lb%0d_phi_inc", k), phi_inc_o, 32'd0);
      end
    end
    rnd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nco_phase_det.md
# nco_phase_det

Phase/frequency detector for the receive end of the NCO path. Each accepted (fsin, fcos) sample pair is converted back to a phase word with an iterative CORDIC in vectoring mode. The block also reports the phase increment since the previous sample, so an NCO's `phi_inc_i` can be recovered from its own outputs. It sits downstream of NCO outputs or mixers, in the same clock/clken domain.

## Interface
- `mpr`, 18: input sample width, signed two's complement
- `apr`, 32: phase/increment word width, 1 turn = 2^apr; 16..32
- `niter`, 16: CORDIC iterations; 8..apr-1
- `clk` input 1: clock
- `reset_n` input 1: asynchronous active-low reset
- `clken` input 1: clock enable; all state advances only on `clk` rising edges with `clken`=1
- `in_valid` input 1: `fsin_i`/`fcos_i` valid
- `fsin_i` input mpr: sine component (y)
- `fcos_i` input mpr: cosine component (x)
- `in_ready` output 1: block can accept a sample
- `phase_o` output apr: atan2(fsin_i, fcos_i) in turns × 2^apr, range [0, 2^apr)
- `phi_inc_o` output apr: `phase_o` minus previous `phase_o`, mod 2^apr
- `inc_valid` output 1: `phi_inc_o` meaningful (a previous sample exists)
- `out_valid` output 1: `phase_o`/`phi_inc_o` updated

## Operation
- Reset (async, `reset_n`=0): state IDLE; `in_ready`=1; `out_valid`=0; `inc_valid`=0; `phase_o`=0; `phi_inc_o`=0; previous-phase register=0; have_prev=0.
- IDLE: `in_ready`=1. An enabled edge with `in_valid`=1 accepts the sample. `in_valid` is ignored while `in_ready`=0, with no back-pressure queue.
- Accept/pre-rotation: sign-extend inputs to mpr+2 bits.
  - If `fcos_i`<0: x=-fcos, y=-fsin, z=2^(apr-1).
  - Else: x=fcos, y=fsin, z=0.
  - iter counter=0; go to ITER.
  - Zero-vector flag = (fsin_i==0 && fcos_i==0).
- ITER, one iteration per enabled edge, i=0..niter-1, arithmetic shifts:
  - y≥0: x+=y>>>i, y-=x>>>i, z+=atan_i.
  - y<0: x-=y>>>i, y+=x>>>i, z-=atan_i.
  - All x/y use old values. z wraps mod 2^apr.
  - atan_i = round(atan(2^-i)/(2π)·2^32) >> (32-apr), from a fixed 32-entry constant table.
- After iteration niter-1, go to OUT.
- OUT (one enabled edge):
  - phase = zero-vector ? 0 : z.
  - `phase_o`←phase.
  - `phi_inc_o`←phase−prev (mod 2^apr).
  - `inc_valid`←have_prev.
  - prev←phase; have_prev←1; `out_valid`←1; go to IDLE.
- `out_valid` is a one-enabled-cycle pulse: it clears on the next enabled edge. `phase_o`, `phi_inc_o` and `inc_valid` hold until the next OUT.
- x/y grow by the CORDIC gain (≤1.65) plus the pre-rotation negation of −2^(mpr-1); mpr+2 bits guarantee no overflow.
- The CORDIC gain is not compensated; magnitude is not an output.

## Timing
- Accept edge E0 → ITER edges E1..E_niter → OUT edge E_(niter+1). `out_valid` rises after E_(niter+1). Latency is niter+1 enabled edges (17 at defaults).
- `in_ready` is 0 from after E0 until after E_(niter+1). The next accept is earliest at E_(niter+2), giving throughput 1 sample / (niter+2) enabled cycles.
- `clken`=0 freezes everything, including `out_valid` level.
- Reset asserted mid-ITER/OUT aborts the computation: no `out_valid` is produced and have_prev is cleared.
- Phase wrap: prev=0xF000_0000, new=0x1000_0000 → `phi_inc_o`=0x2000_0000.

## Configuration
- `NCO_PHASE_DET_INC_EN` defined: previous-phase register, subtractor, have_prev, and `phi_inc_o`/`inc_valid` logic are present as described.
- Not defined: that logic is removed; `phi_inc_o` is tied to 0 and `inc_valid` to 0. `phase_o`, `out_valid` and timing are unchanged.

## Test plan
All tests at defaults; phase tolerance is ±2^16 counts.
- Reset then idle → `in_ready`=1, `out_valid`=0, `phase_o`=0, `phi_inc_o`=0, `inc_valid`=0.
- fcos=131071, fsin=0 → `out_valid` 17 enabled cycles after accept; `phase_o`≈0x0000_0000; `inc_valid`=0.
- Sequence (0,131071), (−131072,0), (0,−131072) as (fcos,fsin) → `phase_o`≈0x4000_0000, 0x8000_0000, 0xC000_0000; `phi_inc_o`≈0x4000_0000 for the 2nd and 3rd, `inc_valid`=1.
- Loopback from the NCO with `phi_inc_i`=0x0100_0000, one sample per 18 clocks, `clken` randomly held low 30% of cycles → every `phi_inc_o` after the first ≈0x0100_0000 ±2^17; no sample lost or duplicated.
- Zero vector (0,0) → `phase_o`=0. `in_valid` pulsed while `in_ready`=0 → ignored, exactly one `out_valid` per accept.
- `reset_n` low at iteration 8 → no `out_valid`; the next sample after reset gives `inc_valid`=0.
